// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package adder_seq_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} adder_seq_state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple adder slice with carry-in and carry-out.
module adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [4:0] w_full;

  assign w_full  = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, carry_i};
  assign sum_o   = w_full[3:0];
  assign carry_o = w_full[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one adder4 slice, LSB nibble first,
// with ready/valid handshakes on both the command and the result side.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int NIB_N = WIDTH / NIBBLE_W;
  localparam int CNT_W = $clog2(NIB_N);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  adder_seq_state_t    r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_c;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum_nib;
  logic                w_cout;
  logic                w_last;

  // Operand nibble mux: a decoded select keeps every index a constant.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned i = 0; i < NIB_N; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  assign w_last = (r_cnt == CNT_W'(NIB_N - 1));

  adder4 u_slice (
    .a_i     (w_a_nib),
    .b_i     (w_b_nib),
    .carry_i (r_c),
    .sum_o   (w_sum_nib),
    .carry_o (w_cout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_a     <= a_i;
            r_b     <= sub_i ? ~b_i : b_i;
            r_c     <= sub_i ? 1'b1 : carry_i;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          for (int unsigned i = 0; i < NIB_N; i++) begin
            if (r_cnt == CNT_W'(i)) r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_sum_nib;
          end
          r_c <= w_cout;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == IDLE) && !rst_i;
  assign valid_o = (r_state == DONE);
  assign sum_o   = r_sum;
  assign carry_o = r_c;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed and randomized checks of adder_seq_ctrl (WIDTH=32) against hand values and a 33-bit model.
module tb_adder_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        carry_i;
  logic        sub_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] sum_o;
  logic        carry_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  adder_seq_ctrl #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .sub_i   (sub_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a command and hold it until an edge with ready_o high takes it.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    int waited = 0;
    while (!ready_o && waited < 20) begin
      tick();
      waited++;
    end
    if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
    a_i = a; b_i = b; carry_i = c; sub_i = s; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] es, input logic ec);
    int lat = 0;
    while (!valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},   64'(lat),     64'd8);
    check({tag, "_sum"},   64'(sum_o),   64'(es));
    check({tag, "_carry"}, 64'(carry_o), 64'(ec));
  endtask

  task automatic stall(input string tag, input int n, input logic [31:0] es, input logic ec);
    for (int k = 0; k < n; k++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(valid_o), 64'd1);
      check({tag, "_hold_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_hold_sum"},   64'(sum_o),   64'(es));
      check({tag, "_hold_carry"}, 64'(carry_o), 64'(ec));
    end
  endtask

  task automatic release_result(input string tag);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, "_once"}, 64'(valid_o), 64'd0);
    check({tag, "_idle"}, 64'(ready_o), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [31:0] es, input logic ec);
    accept(a, b, c, s);
    wait_result(tag, es, ec);
    release_result(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs;
    logic [32:0] model;
    int          nst;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
    tick(); tick();
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_sum",   64'(sum_o),   64'd0);
    check("rst_carry", 64'(carry_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check("rst_release_ready", 64'(ready_o), 64'd1);

    // Reset in the middle of a calculation.
    accept(32'h12345678, 32'h1, 1'b0, 1'b0);
    tick(); tick();
    rst_i = 1'b1;
    #1;
    check("midrst_ready_comb", 64'(ready_o), 64'd0);
    tick();
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_sum",   64'(sum_o),   64'd0);
    for (int k = 0; k < 10; k++) tick();
    check("midrst_no_result", 64'(valid_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check("midrst_release_ready", 64'(ready_o), 64'd1);
    run_op("add2p3", 32'd2, 32'd3, 1'b0, 1'b0, 32'h00000005, 1'b0);

    run_op("ripple",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1);
    run_op("carryin", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0);
    run_op("sub7m5",  32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1);
    run_op("sub5m7",  32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);

    // Backpressure with a new command held during DONE.
    accept(32'h0000_00F0, 32'h0000_0010, 1'b0, 1'b0);
    wait_result("bp", 32'h00000100, 1'b0);
    a_i = 32'h80000000; b_i = 32'h80000000; carry_i = 1'b1; sub_i = 1'b0; valid_i = 1'b1;
    stall("bp", 10, 32'h00000100, 1'b0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("bp_to_idle_valid", 64'(valid_o), 64'd0);
    check("bp_to_idle_ready", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    check("bp_pending_taken", 64'(ready_o), 64'd0);
    wait_result("bp_pending", 32'h00000001, 1'b1);
    release_result("bp_pending");

    for (int n = 0; n < 2000; n++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (rs) model = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
      else    model = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      nst = $urandom_range(0, 3);
      accept(ra, rb, rc, rs);
      wait_result("rand", model[31:0], model[32]);
      stall("rand", nst, model[31:0], model[32]);
      release_result("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
